// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state to the state set.
package fifo_uart_tx_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_CLKS_PER_BIT = 868;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_POP    = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd5;
`endif
    localparam logic [2:0] ST_STOP   = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        POP    = ST_POP,
        LOAD   = ST_LOAD,
        START  = ST_START,
        DATA   = ST_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY = ST_PARITY,
`endif
        STOP   = ST_STOP
    } tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_baud_counter.sv
// Bit-period timer: down-counter that ticks at terminal count 0 and reloads there.
// While clear is high the counter is held at the full period so the next bit starts clean.
module baud_counter
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign tick = !clear && (cnt_q == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from a source FIFO and serialises them LSB first.
// Build with FIFO_UART_TX_PARITY_EN to append an even-parity bit after the data bits.
//
// state  | meaning
// IDLE   | line high; pop one word when the FIFO is non-empty
// POP    | FIFO read latency cycle
// LOAD   | capture pop_data into the shift register
// START  | start bit (tx=0)
// DATA   | WIDTH data bits, LSB first
// PARITY | even parity of the data bits (parity build only)
// STOP   | stop bit (tx=1), then frame_done and back to IDLE
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             empty,
    output logic             pop_en,
    input  logic [WIDTH-1:0] pop_data,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int               IDX_W    = $clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    tx_state_t        state_q;
    logic [WIDTH-1:0] shift_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic [1:0]       arm_q;
    logic             tick;
    logic             bit_clear;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             parity_q;
`endif

    // arm_q keeps pop_en off until the second clock edge after reset release
    assign pop_en    = (state_q == IDLE) && !empty && arm_q[1];
    assign busy      = pop_en || (state_q != IDLE);
    assign bit_clear = (state_q == IDLE) || (state_q == POP) || (state_q == LOAD);

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(bit_clear),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q <= '0;
        end else begin
            arm_q <= {arm_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx         <= 1'b1;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            frame_done <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop_en) begin
                        state_q <= POP;
                    end
                end
                POP: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    shift_q <= pop_data;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_q <= ^pop_data;
`endif
                    tx      <= 1'b0;
                    state_q <= START;
                end
                START: begin
                    if (tick) begin
                        tx        <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx_q == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            tx      <= parity_q;
                            state_q <= PARITY;
`else
                            tx      <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            tx        <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tx      <= 1'b1;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        frame_done <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx (WIDTH=8, CLKS_PER_BIT=4) fed by a DEPTH=4 FIFO model.
// A frame-level reference predicts pop_en, tx, busy and frame_done for every cycle.
module tb_fifo_uart_tx;

    localparam int WIDTH = 8;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = WIDTH + 3;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = WIDTH + 2;
    localparam bit PAR   = 1'b0;
`endif
    localparam int FRAME = NBITS * CPB;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             empty = 1'b1;
    logic [WIDTH-1:0] pop_data = '0;
    logic             pop_en;
    logic             tx;
    logic             busy;
    logic             frame_done;

    fifo_uart_tx #(
        .WIDTH       (WIDTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .empty     (empty),
        .pop_en    (pop_en),
        .pop_data  (pop_data),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] sent_q[$];
    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // source FIFO: registered read data, empty flag updated on the clock
    always @(posedge clk) begin
        if (pop_en && fifo_q.size() > 0) begin
            pop_data <= fifo_q.pop_front();
        end
        empty <= (fifo_q.size() == 0);
    end

    task automatic push(input logic [WIDTH-1:0] w);
        if (fifo_q.size() < DEPTH) begin
            fifo_q.push_back(w);
            sent_q.push_back(w);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // reference: a frame occupies the line from pop cycle N; start bit at N+3,
    // frame_done and the earliest next pop at N+3+FRAME
    bit exp_tx[int];
    bit exp_busy[int];
    bit exp_fd[int];
    int free_at = 0;
    int arm_at  = 1 << 30;
    bit in_rst  = 1'b1;
    bit e_pop;
    bit b;
    logic [WIDTH-1:0] w;

    always @(negedge clk) begin
        e_pop = 1'b0;
        if (!rst_n) begin
            in_rst = 1'b1;
            exp_tx.delete();
            exp_busy.delete();
            exp_fd.delete();
            free_at = 0;
            arm_at  = 1 << 30;
        end else begin
            if (in_rst) begin
                in_rst = 1'b0;
                arm_at = cyc + 2;
            end
            e_pop = (cyc >= free_at) && (cyc >= arm_at) && !empty && (sent_q.size() > 0);
            if (e_pop) begin
                w = sent_q.pop_front();
                for (int k = 0; k < NBITS; k++) begin
                    if (k == 0)              b = 1'b0;
                    else if (k <= WIDTH)     b = w[k-1];
                    else if (PAR && k == WIDTH + 1) b = ^w;
                    else                     b = 1'b1;
                    for (int j = 0; j < CPB; j++) exp_tx[cyc + 3 + k*CPB + j] = b;
                end
                for (int t = 0; t <= FRAME + 2; t++) exp_busy[cyc + t] = 1'b1;
                exp_fd[cyc + 3 + FRAME] = 1'b1;
                free_at = cyc + 3 + FRAME;
            end
        end
        check_val("pop_en", pop_en, e_pop);
        check_val("tx", tx, exp_tx.exists(cyc) ? exp_tx[cyc] : 1'b1);
        check_val("busy", busy, exp_busy.exists(cyc) ? exp_busy[cyc] : 1'b0);
        check_val("frame_done", frame_done, exp_fd.exists(cyc) ? exp_fd[cyc] : 1'b0);
        cyc++;
    end

    initial begin
        int p;
        int n;
        rst_n = 1'b0;
        wait_cycles(3);
        rst_n = 1'b1;

        // single word
        wait_cycles(1);
        push(8'hA5);
        wait_cycles(FRAME + 15);
        check_val("single_empty", empty, 1'b1);
        check_val("single_level", fifo_q.size(), 0);

        // burst of four
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        wait_cycles(4 * (FRAME + 3) + 10);
        check_val("burst_drained", sent_q.size(), 0);

        // idle with empty FIFO
        wait_cycles(200);

        // reset during data bit 3 of 8'hFF, two words left behind in the FIFO
        push(8'hFF);
        push(8'h5A);
        push(8'hC3);
        wait_cycles(21);
        rst_n = 1'b0;
        #1;
        check_val("rst_tx", tx, 1'b1);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_fifo_left", fifo_q.size(), 2);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2 * (FRAME + 3) + 10);
        check_val("rst_drained", fifo_q.size(), 0);

        // parity patterns
        push(8'h07);
        wait_cycles(FRAME + 10);
        push(8'h03);
        wait_cycles(FRAME + 10);

        // late push while the previous frame is in its stop bit
        push(8'h3C);
        wait_cycles(5 + (NBITS - 1) * CPB);
        push(8'hE7);
        wait_cycles(CPB - 1);
        check_val("late_pop", pop_en, 1'b1);
        check_val("late_fd", frame_done, 1'b1);
        wait_cycles(FRAME + 10);

        // randomized bursts and gaps
        for (int i = 0; i < 8; i++) begin
            if (fifo_q.size() < DEPTH) begin
                n = $urandom_range(DEPTH - fifo_q.size(), 1);
                for (int k = 0; k < n; k++) push(WIDTH'($urandom));
            end
            p = $urandom_range(3 * FRAME, 0);
            wait_cycles(p);
        end

        wait_cycles(DEPTH * (FRAME + 3) + 20);
        check_val("final_fifo", fifo_q.size(), 0);
        check_val("final_ref", sent_q.size(), 0);
        check_val("final_idle_tx", tx, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter WIDTH, default 8: data bits per frame and width of pop_data.
REQ-002 Parameter CLKS_PER_BIT, default 868: clk cycles per serial bit period (>=2).
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 empty  input  1  source FIFO empty flag.
REQ-006 pop_en  output  1  pop request to source FIFO, one-cycle pulse per word.
REQ-007 pop_data  input  WIDTH  FIFO read data, valid the cycle after pop_en.
REQ-008 tx  output  1  serial line, idle high.
REQ-009 busy  output  1  high from the pop cycle through the end of the stop bit.
REQ-010 frame_done  output  1  one-cycle pulse in the cycle after the stop bit ends.

Function
REQ-011 The block SHALL use states IDLE, POP, LOAD, START, DATA, [PARITY], STOP.
REQ-012 IDLE with empty=0: assert pop_en for that cycle and go to POP; with empty=1: stay in IDLE with pop_en=0.
REQ-013 pop_en SHALL never be asserted while empty=1, and SHALL never be high for two consecutive cycles.
REQ-014 POP: wait one cycle, go to LOAD. LOAD: capture pop_data into the shift register, go to START.
REQ-015 START: tx=0 for exactly CLKS_PER_BIT cycles.
REQ-016 DATA: WIDTH bits, LSB first, each held for exactly CLKS_PER_BIT cycles.
REQ-017 STOP: tx=1 for exactly CLKS_PER_BIT cycles, then pulse frame_done and return to IDLE.
REQ-018 Back-to-back: with empty=0 at the end of STOP, the next pop_en SHALL occur in the frame_done cycle, giving frame spacing of CLKS_PER_BIT*(WIDTH+2[+1]) + 3 cycles.
REQ-019 Changes on empty or pop_data outside IDLE and LOAD SHALL be ignored; a frame in progress SHALL always complete.
REQ-020 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) wide and reload at 0 on every bit boundary.
REQ-021 The bit index counter SHALL be $clog2(WIDTH+1) wide.
REQ-022 tx SHALL be registered, with no combinational path from any input.

Reset
REQ-023 While rst_n=0: state=IDLE, tx=1, pop_en=0, busy=0, frame_done=0, counters=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 in the same cycle) without issuing any further pop.
REQ-025 After rst_n deasserts, the first pop_en SHALL occur no earlier than the second posedge.

Configuration
REQ-026 Macro FIFO_UART_TX_PARITY_EN defined: insert a PARITY state after DATA that drives even parity (XOR of the data bits) for CLKS_PER_BIT cycles.
REQ-027 Macro FIFO_UART_TX_PARITY_EN undefined: the PARITY state and its logic SHALL not exist; DATA goes directly to STOP.

Structure
REQ-028 Shared package fifo_uart_tx_pkg SHALL hold the state enum typedef (tx_state_t) and the default constants (DEF_WIDTH, DEF_CLKS_PER_BIT).
REQ-029 One sub-module, baud_counter (parameter CLKS_PER_BIT, inputs clk/rst_n/clear, output tick), SHALL generate the bit-boundary tick.

Verification (WIDTH=8, CLKS_PER_BIT=4, source is the team fifo with DEPTH=4)
REQ-030 Single word: push 8'hA5 into the FIFO -> exactly one pop_en; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; frame_done one pulse; empty=1 afterwards.
REQ-031 Burst: push 1,2,3,4 -> four frames carrying 1..4 in order; pop_en spacing 43 cycles (47 with parity); no pop while empty.
REQ-032 Empty idle: empty held at 1 for 200 cycles -> pop_en=0, tx=1, busy=0 throughout.
REQ-033 Mid-frame reset: rst_n low during DATA bit 3 of 8'hFF -> tx=1 the same cycle, state IDLE; the remaining FIFO words are transmitted intact after release.
REQ-034 Parity build: with FIFO_UART_TX_PARITY_EN defined, send 8'h07 -> parity bit 1 for 4 cycles; send 8'h03 -> parity bit 0.
REQ-035 Late push: push a word while a frame is in STOP -> the next pop_en occurs in the frame_done cycle.
